condicionador_de_entrada: RTL and testbench
===========================================

CONDICIONADOR_DE_ENTRADA -- requirements
Module: condicionador_de_entrada

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, clock cycles between debounce sample ticks; legal range ≥ 2.
REQ-002 CLK  input  1  single system clock; all state rises on posedge CLK.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 CH0..CH7  input  1 each  raw board switches, asynchronous to CLK, active-high.
REQ-005 BTN0..BTN3  input  1 each  raw push buttons, asynchronous to CLK, active-low (0 = pressed).
REQ-006 USER0  output  3  conditioned user-0 code {CH0,CH1,CH2}.
REQ-007 FUNC0  output  3  user-0 function {CH3, T0, T1}; T0/T1 are toggle bits driven by BTN0/BTN1.
REQ-008 USER1  output  3  conditioned user-1 code {CH4,CH5,CH6}.
REQ-009 FUNC1  output  3  user-1 function {CH7, T2, T3}; T2/T3 are toggle bits driven by BTN2/BTN3.
REQ-010 UPD0, UPD1  output  1 each  one-cycle pulse marking a change of {USER0,FUNC0} or {USER1,FUNC1}.

Function
REQ-011 Each of the 12 raw inputs SHALL pass through a two-flop synchronizer before any other use.
REQ-012 A shared prescaler SHALL count 0..DEBOUNCE_CYCLES-1, wrap to 0, and assert TICK for one cycle when it equals DEBOUNCE_CYCLES-1.
REQ-013 On each TICK, every synchronized signal SHALL be shifted into its own 3-sample history.
REQ-014 A debounced level SHALL change only on a TICK cycle where all 3 history samples agree and differ from the current debounced level.
REQ-015 A synchronized pulse that does not persist for 3 consecutive TICK samples SHALL produce no change.
REQ-016 Switch outputs (USERx, FUNCx[2]) SHALL be registered copies of the debounced switch levels, updating the cycle after the debounced transition.
REQ-017 A toggle bit Tn SHALL invert exactly once per debounced BTNn transition from 1 to 0; releases (0 to 1) SHALL have no effect.
REQ-018 Worst-case latency from a stable raw change to the output SHALL be ≤ 2 + 3*DEBOUNCE_CYCLES + 1 cycles.
REQ-019 UPDx SHALL be a registered pulse, high in exactly the first cycle the new USERx/FUNCx value is visible.
REQ-020 UPDx SHALL be high for one cycle only, even if several bits of the same user change in that cycle.
REQ-021 Simultaneous events (any mix of buttons and switches, both users) SHALL all be applied in the same cycle; UPD0 and UPD1 are then independent.
REQ-022 A button held pressed indefinitely SHALL cause exactly one toggle.

Reset
REQ-023 RST_N low SHALL immediately clear USER0, FUNC0, USER1, FUNC1, UPD0, UPD1, toggle bits and the prescaler to 0.
REQ-024 During reset, switch synchronizers, histories and debounced levels SHALL reset to 0; button ones SHALL reset to 1 (released).
REQ-025 Reset deassertion with buttons released SHALL generate no toggle and no UPD pulse.
REQ-026 Reset asserted mid-debounce SHALL discard the partial history; debouncing restarts from the reset state after release.

Structure
REQ-027 A shared package SHALL hold the 3-bit user-code and function-code typedefs, the default DEBOUNCE_CYCLES and the released button level constant.
REQ-028 A sub-module filtro_debounce SHALL contain the synchronizer, 3-sample history and debounced level for one signal, with a reset-level parameter, TICK input and a falling-edge output.
REQ-029 filtro_debounce SHALL be instantiated 12 times; the prescaler, toggle bits, output registers and UPD logic SHALL sit in the top module.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 Reset with BTN0..3 = 1 and CH = 0, then release -> all outputs 0, no UPD pulse over 100 cycles.
REQ-031 CH0..CH2 = 1,0,1 held -> USER0 = 101 within 15 cycles, a single UPD0 pulse, USER1/UPD1 unchanged.
REQ-032 BTN0 low for 5 cycles (< 3 ticks) then high -> FUNC0 stays 000, no UPD0.
REQ-033 BTN0 held low for 40 cycles, released, pressed again for 40 cycles -> FUNC0[1] goes 0 -> 1 -> 0, exactly two UPD0 pulses.
REQ-034 BTN1 and BTN2 fall in the same cycle -> FUNC0[0] and FUNC1[1] become 1 in the same cycle, with UPD0 and UPD1 pulsing together.
REQ-035 RST_N pulsed low during a stable BTN3 press, 2 ticks in -> outputs cleared at once; after release with BTN3 released, FUNC1 = 000 and no UPD1.

Source files
------------

// File: rtl/condicionador_de_entrada_pkg.sv
// Shared types and constants for the input conditioner.
package condicionador_de_entrada_pkg;

  typedef logic [2:0] user_code_t;
  typedef logic [2:0] func_code_t;

  localparam int   DEBOUNCE_CYCLES_DEF = 50000;
  localparam logic BTN_RELEASED        = 1'b1;
  localparam logic SW_RESET_LEVEL      = 1'b0;

endpackage

// File: rtl/condicionador_de_entrada_filtro.sv
// filtro_debounce: two-flop synchronizer, 3-sample tick history and debounced
// level for one raw input. fall pulses for one cycle when the level drops 1->0.
module filtro_debounce
  import condicionador_de_entrada_pkg::*;
#(
  parameter logic RESET_LEVEL = SW_RESET_LEVEL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic       sync_a;
  logic       sync_b;
  logic [2:0] hist;
  logic [2:0] hist_next;
  logic       change;

  // The freshly shifted sample takes part in the vote, so three ticks suffice.
  assign hist_next = {hist[1:0], sync_b};
  assign change    = (hist_next == {3{hist_next[0]}}) && (hist_next[0] != level);

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= RESET_LEVEL;
      sync_b <= RESET_LEVEL;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Sample on each tick and move the level only when three samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= {3{RESET_LEVEL}};
      level <= RESET_LEVEL;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (tick) begin
        hist <= hist_next;
        if (change) begin
          level <= hist_next[0];
          fall  <= ~hist_next[0];
        end
      end
    end
  end

endmodule

// File: rtl/condicionador_de_entrada.sv
// Input conditioner: debounces 8 switches and 4 active-low buttons, turns
// button presses into toggle bits and publishes two user code/function pairs
// with a one-cycle update strobe per user.
module condicionador_de_entrada
  import condicionador_de_entrada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ch0,
  input  logic       ch1,
  input  logic       ch2,
  input  logic       ch3,
  input  logic       ch4,
  input  logic       ch5,
  input  logic       ch6,
  input  logic       ch7,
  input  logic       btn0,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  output logic [2:0] user0,
  output logic [2:0] func0,
  output logic [2:0] user1,
  output logic [2:0] func1,
  output logic       upd0,
  output logic       upd1
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] presc;
  logic          tick;
  logic [7:0]    sw_raw;
  logic [3:0]    btn_raw;
  logic [7:0]    sw_lvl;
  logic [7:0]    sw_fall_unused;
  logic [3:0]    btn_lvl_unused;
  logic [3:0]    btn_fall;
  logic [7:0]    sw_q;
  logic [3:0]    tgl;
  logic [3:0]    tgl_next;
  user_code_t    user0_next;
  user_code_t    user1_next;
  func_code_t    func0_next;
  func_code_t    func1_next;

  assign sw_raw  = {ch7, ch6, ch5, ch4, ch3, ch2, ch1, ch0};
  assign btn_raw = {btn3, btn2, btn1, btn0};
  assign tick    = (presc == LAST);

  // Shared sample-tick prescaler, wraps after DEBOUNCE_CYCLES counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + CW'(1);
  end

  for (genvar i = 0; i < 8; i++) begin : g_sw
    filtro_debounce #(.RESET_LEVEL(SW_RESET_LEVEL)) u_filtro (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (sw_raw[i]),
      .level (sw_lvl[i]),
      .fall  (sw_fall_unused[i])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    filtro_debounce #(.RESET_LEVEL(BTN_RELEASED)) u_filtro (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (btn_raw[i]),
      .level (btn_lvl_unused[i]),
      .fall  (btn_fall[i])
    );
  end

  // Next visible values; the update strobe compares these with what is shown now.
  assign tgl_next   = tgl ^ btn_fall;
  assign user0_next = {sw_lvl[0], sw_lvl[1], sw_lvl[2]};
  assign func0_next = {sw_lvl[3], tgl_next[0], tgl_next[1]};
  assign user1_next = {sw_lvl[4], sw_lvl[5], sw_lvl[6]};
  assign func1_next = {sw_lvl[7], tgl_next[2], tgl_next[3]};

  assign user0 = {sw_q[0], sw_q[1], sw_q[2]};
  assign func0 = {sw_q[3], tgl[0], tgl[1]};
  assign user1 = {sw_q[4], sw_q[5], sw_q[6]};
  assign func1 = {sw_q[7], tgl[2], tgl[3]};

  // Output registers, toggle bits and one-cycle update strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q <= '0;
      tgl  <= '0;
      upd0 <= 1'b0;
      upd1 <= 1'b0;
    end else begin
      sw_q <= sw_lvl;
      tgl  <= tgl_next;
      upd0 <= ({user0_next, func0_next} != {user0, func0});
      upd1 <= ({user1_next, func1_next} != {user1, func1});
    end
  end

endmodule

// File: tb/tb_condicionador_de_entrada.sv
// Directed bench for condicionador_de_entrada with DEBOUNCE_CYCLES = 4.
module tb_condicionador_de_entrada;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] chv;
  logic [3:0] btnv;
  logic [2:0] user0, func0, user1, func1;
  logic       upd0, upd1;

  int n_checks = 0;
  int n_errs   = 0;
  int n_upd0   = 0;
  int n_upd1   = 0;
  int base0, base1, lat;

  condicionador_de_entrada #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ch0   (chv[0]), .ch1 (chv[1]), .ch2 (chv[2]), .ch3 (chv[3]),
    .ch4   (chv[4]), .ch5 (chv[5]), .ch6 (chv[6]), .ch7 (chv[7]),
    .btn0  (btnv[0]), .btn1 (btnv[1]), .btn2 (btnv[2]), .btn3 (btnv[3]),
    .user0 (user0),
    .func0 (func0),
    .user1 (user1),
    .func1 (func1),
    .upd0  (upd0),
    .upd1  (upd1)
  );

  always #5 clk = ~clk;

  // Count update strobes away from the active edge.
  always @(negedge clk) begin
    if (upd0) n_upd0++;
    if (upd1) n_upd1++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    chv   = 8'h00;
    btnv  = 4'hF;
    #3 rst_n = 1'b0;
    wait_cyc(3);

    // Power-up reset and quiet release.
    check_val("rst_user0", user0, 3'b000);
    check_val("rst_func1", func1, 3'b000);
    rst_n = 1'b1;
    base0 = n_upd0; base1 = n_upd1;
    wait_cyc(100);
    check_val("idle_upd0", n_upd0 - base0, 0);
    check_val("idle_upd1", n_upd1 - base1, 0);
    check_val("idle_outs", {user0, func0, user1, func1}, 12'h000);

    // Switch code for user 0: ch0..ch2 = 1,0,1.
    base0 = n_upd0; base1 = n_upd1;
    chv[0] = 1'b1; chv[1] = 1'b0; chv[2] = 1'b1;
    lat = 0;
    while (user0 != 3'b101 && lat < 20) begin
      wait_cyc(1);
      lat++;
    end
    check_val("sw_latency_ok", lat <= 15, 1);
    check_val("sw_user0", user0, 3'b101);
    check_val("sw_upd0_first", upd0, 1'b1);
    check_val("sw_upd1_quiet", upd1, 1'b0);
    wait_cyc(20);
    check_val("sw_upd0_count", n_upd0 - base0, 1);
    check_val("sw_upd1_count", n_upd1 - base1, 0);
    check_val("sw_user1", user1, 3'b000);

    // Short glitch on btn0 is rejected.
    base0 = n_upd0;
    btnv[0] = 1'b0;
    wait_cyc(5);
    btnv[0] = 1'b1;
    wait_cyc(40);
    check_val("glitch_func0", func0, 3'b000);
    check_val("glitch_upd0", n_upd0 - base0, 0);

    // Long presses on btn0 toggle once each; releases do nothing.
    base0 = n_upd0;
    btnv[0] = 1'b0;
    wait_cyc(40);
    check_val("press1_func0", func0, 3'b010);
    check_val("press1_upd0", n_upd0 - base0, 1);
    btnv[0] = 1'b1;
    wait_cyc(40);
    check_val("rel1_func0", func0, 3'b010);
    check_val("rel1_upd0", n_upd0 - base0, 1);
    btnv[0] = 1'b0;
    wait_cyc(40);
    check_val("press2_func0", func0, 3'b000);
    check_val("press2_upd0", n_upd0 - base0, 2);
    btnv[0] = 1'b1;
    wait_cyc(40);
    check_val("rel2_upd0", n_upd0 - base0, 2);

    // btn1 and btn2 together: both users update in the same cycle.
    btnv[1] = 1'b0; btnv[2] = 1'b0;
    lat = 0;
    while (func0[0] == 1'b0 && func1[1] == 1'b0 && lat < 20) begin
      wait_cyc(1);
      lat++;
    end
    check_val("simul_func0", func0, 3'b001);
    check_val("simul_func1", func1, 3'b010);
    check_val("simul_upd0", upd0, 1'b1);
    check_val("simul_upd1", upd1, 1'b1);
    btnv[1] = 1'b1; btnv[2] = 1'b1;
    wait_cyc(40);

    // Reset two ticks into a btn3 press discards the partial debounce.
    btnv[3] = 1'b0;
    wait_cyc(10);
    check_val("midpress_func1", func1, 3'b010);
    rst_n = 1'b0;
    #1;
    check_val("async_user0", user0, 3'b000);
    check_val("async_func0", func0, 3'b000);
    check_val("async_func1", func1, 3'b000);
    check_val("async_upd", {upd0, upd1}, 2'b00);
    btnv[3] = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    base1 = n_upd1;
    wait_cyc(60);
    check_val("post_func1", func1, 3'b000);
    check_val("post_upd1", n_upd1 - base1, 0);
    check_val("post_user0", user0, 3'b101);
    check_val("post_func0", func0, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
